// File: rtl/fifo_wr_pkg.sv
// Shared constants and pointer-code helpers for the FIFO write-side controller.
package fifo_wr_pkg;

    localparam int FN_W = 32;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_cntrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 and
// returns a one-hot grant plus its index; the history register lives in the parent.
module rr_arbiter
    import fifo_wr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic                en,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    int                idx;
    logic [ID_WIDTH-1:0] sel;
    logic              found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            sel = ID_WIDTH'(idx);
            if (en && !found && req[sel]) begin
                grant[sel] = 1'b1;
                grant_id   = sel;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb_cntrl.sv
// Write-side controller of the async FIFO: arbitrates requesters onto the memory
// write port, owns the write pointer and full flag. Optional: FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_arb_cntrl
    import fifo_wr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 8,
    parameter int NUM_REQ    = 4,
    parameter int AF_THRESH  = 2,
    localparam int PTR_WIDTH = ptr_width(MEM_DEPTH),
    localparam int ID_WIDTH  = id_width(NUM_REQ)
) (
    input  logic                          W_clk,
    input  logic                          W_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [PTR_WIDTH-1:0]          rd_ptr_gray_sync,
    output logic                          mem_wclk_en,
    output logic [PTR_WIDTH-2:0]          mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [PTR_WIDTH-1:0]          wr_ptr_gray,
    output logic                          full,
    output logic [ID_WIDTH-1:0]           grant_id
`ifdef FIFO_WR_ALMOST_FULL_EN
    ,
    output logic                          almost_full
`endif
);

    // Full when write Gray equals read Gray with the top two bits inverted.
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

    logic [NUM_REQ-1:0]   grant;
    logic [ID_WIDTH-1:0]  gid;
    logic [ID_WIDTH-1:0]  last_grant;
    logic [PTR_WIDTH-1:0] wr_ptr_bin;
    logic [PTR_WIDTH-1:0] wr_bin_next;
    logic [PTR_WIDTH-1:0] gray_next;
    logic                 transfer;
    logic                 full_next;

    // Reset also gates the arbiter so nothing is granted while W_rst is low.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .en         (~full & W_rst),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (gid)
    );

    assign req_ready   = grant;
    assign grant_id    = gid;
    assign transfer    = |(req_valid & grant);
    assign mem_wclk_en = transfer;
    assign mem_waddr   = wr_ptr_bin[PTR_WIDTH-2:0];

    always_comb begin
        mem_wdata = '0;
        if (|grant) mem_wdata = req_data[gid*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wr_bin_next = wr_ptr_bin + PTR_WIDTH'(transfer);
    assign gray_next   = PTR_WIDTH'(bin2gray(FN_W'(wr_bin_next)));
    assign full_next   = (gray_next == (rd_ptr_gray_sync ^ FULL_MASK));

    always_ff @(posedge W_clk or negedge W_rst) begin
        if (!W_rst) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            last_grant  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            wr_ptr_bin  <= wr_bin_next;
            wr_ptr_gray <= gray_next;
            full        <= full_next;
            if (transfer) last_grant <= gid;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    logic [PTR_WIDTH-1:0] rd_bin;
    logic [PTR_WIDTH-1:0] free_slots;

    assign rd_bin     = PTR_WIDTH'(gray2bin(FN_W'(rd_ptr_gray_sync)));
    assign free_slots = PTR_WIDTH'(MEM_DEPTH) - (wr_bin_next - rd_bin);

    always_ff @(posedge W_clk or negedge W_rst) begin
        if (!W_rst) almost_full <= 1'b0;
        else        almost_full <= (free_slots <= PTR_WIDTH'(AF_THRESH));
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb_cntrl.sv
// Directed bench for fifo_wr_arb_cntrl (default parameters: 8-bit data, depth 8, 4 requesters).
module tb_fifo_wr_arb_cntrl;

    logic        W_clk = 1'b0;
    logic        W_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rd_ptr_gray_sync;
    logic        mem_wclk_en;
    logic [2:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [3:0]  wr_ptr_gray;
    logic        full;
    logic [1:0]  grant_id;
`ifdef FIFO_WR_ALMOST_FULL_EN
    logic        almost_full;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_wr_arb_cntrl dut (
        .W_clk            (W_clk),
        .W_rst            (W_rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .mem_wclk_en      (mem_wclk_en),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .wr_ptr_gray      (wr_ptr_gray),
        .full             (full),
        .grant_id         (grant_id)
`ifdef FIFO_WR_ALMOST_FULL_EN
        ,
        .almost_full      (almost_full)
`endif
    );

    always #5 W_clk = ~W_clk;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge W_clk);
        #1;
    endtask

    initial begin
        int exp_id;
        int bin;

        W_rst            = 1'b0;
        req_valid        = 4'b1111;
        req_data         = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rd_ptr_gray_sync = 4'b0000;
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wen", 32'(mem_wclk_en), 32'h0);
        chk("rst_gray", 32'(wr_ptr_gray), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        tick();
        tick();
        W_rst = 1'b1;
        #1;

        // Round-robin fill with all requesters valid
        for (int k = 0; k < 8; k++) begin
            chk("fill_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            chk("fill_id", 32'(grant_id), 32'(k % 4));
            chk("fill_addr", 32'(mem_waddr), 32'(k));
            chk("fill_data", 32'(mem_wdata), 32'(8'hA0 + 8'h11 * (k % 4)));
            chk("fill_wen", 32'(mem_wclk_en), 32'h1);
            chk("fill_full_low", 32'(full), 32'h0);
            tick();
        end
        chk("full_set", 32'(full), 32'h1);
        chk("full_ready", 32'(req_ready), 32'h0);
        chk("full_wen", 32'(mem_wclk_en), 32'h0);
        chk("full_gray", 32'(wr_ptr_gray), 32'hC);
        tick();
        chk("full_hold", 32'(full), 32'h1);

        // One read frees one slot
        rd_ptr_gray_sync = 4'b0001;
        #1;
        chk("rd_adv_same_cycle", 32'(full), 32'h1);
        tick();
        chk("rd_adv_clear", 32'(full), 32'h0);
        chk("refill_ready", 32'(req_ready), 32'h1);
        chk("refill_addr", 32'(mem_waddr), 32'h0);
        tick();
        chk("refull", 32'(full), 32'h1);
        chk("refull_gray", 32'(wr_ptr_gray), 32'hD);
        chk("refull_ready", 32'(req_ready), 32'h0);

        // Drain everything, two requesters alternate
        rd_ptr_gray_sync = 4'b1101;
        req_valid        = 4'b0101;
        req_data         = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        chk("drain_full", 32'(full), 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0) ? 2 : 0;
            chk("alt_id", 32'(grant_id), 32'(exp_id));
            chk("alt_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
            chk("alt_data", 32'(mem_wdata), 32'((exp_id == 2) ? 8'h33 : 8'h11));
            chk("alt_addr", 32'(mem_waddr), 32'(1 + k));
            tick();
        end

        // Twenty writes with the reader keeping up: address and Gray wrap
        req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            bin = 13 + k;
            rd_ptr_gray_sync = gray4(bin);
            #1;
            chk("wrap_addr", 32'(mem_waddr), 32'(bin % 8));
            chk("wrap_gray", 32'(wr_ptr_gray), 32'(gray4(bin)));
            chk("wrap_id", 32'(grant_id), 32'h0);
            chk("wrap_full", 32'(full), 32'h0);
            tick();
        end
        chk("wrap_end_gray", 32'(wr_ptr_gray), 32'h1);

        // Reset in the middle of a burst
        rd_ptr_gray_sync = 4'b0001;
        req_valid        = 4'b1111;
        req_data         = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("burst_id", 32'(grant_id), 32'((k + 1) % 4));
            tick();
        end
        W_rst = 1'b0;
        #1;
        chk("midrst_gray", 32'(wr_ptr_gray), 32'h0);
        chk("midrst_full", 32'(full), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_wen", 32'(mem_wclk_en), 32'h0);
        rd_ptr_gray_sync = 4'b0000;
        #2;
        W_rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_id", 32'(grant_id), 32'h0);
        chk("post_rst_addr", 32'(mem_waddr), 32'h0);

`ifdef FIFO_WR_ALMOST_FULL_EN
        req_valid = 4'b0001;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("af_low", 32'(almost_full), 32'h0);
            tick();
        end
        chk("af_rise", 32'(almost_full), 32'h1);
        req_valid        = 4'b0000;
        rd_ptr_gray_sync = 4'b0001;
        tick();
        chk("af_fall", 32'(almost_full), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_arb_cntrl.md
# fifo_wr_arb_cntrl

Write-side controller for the asynchronous FIFO memory in the W_clk domain. It shares the single memory write port among NUM_REQ requesters through a round-robin valid/ready arbiter. It also owns the write pointer (binary and Gray) and computes the registered full flag against the read pointer, which arrives already synchronized into W_clk. It drives the memory's write-enable, write-address and write-data inputs directly.

## Interface
- DATA_WIDTH, 8, width of each write word.
- MEM_DEPTH, 8, FIFO depth; power of two, ≥ 2.
- NUM_REQ, 4, number of requesters; ≥ 2.
- AF_THRESH, 2, almost-full threshold in free slots (used only with the macro).
- Derived: PTR_WIDTH = clog2(MEM_DEPTH)+1; ID_WIDTH = clog2(NUM_REQ).

Ports:
- W_clk  in  1  write-domain clock.
- W_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; grant to a requester.
- rd_ptr_gray_sync  in  PTR_WIDTH  read pointer in Gray code, already 2-flop synchronized to W_clk.
- mem_wclk_en  out  1  memory write enable.
- mem_waddr  out  PTR_WIDTH-1  memory write address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- wr_ptr_gray  out  PTR_WIDTH  registered Gray write pointer, for the read-side synchronizer.
- full  out  1  registered full flag.
- grant_id  out  ID_WIDTH  index of the current grant; 0 when there is no grant.
- almost_full  out  1  present only with FIFO_WR_ALMOST_FULL_EN.

## Operation
- Arbitration is combinational each cycle.
  - If full=0 and any req_valid is high, grant the first valid requester searching upward from last_grant+1, modulo NUM_REQ.
  - When a grant is made, req_ready asserts only for the selected requester.
  - If full=1, or no requester is valid, req_ready is all zero.
- Transfer = |(req_valid & req_ready).
  - mem_wclk_en = transfer.
  - mem_waddr = wr_ptr_bin[PTR_WIDTH-2:0].
  - mem_wdata = the selected requester's slice. It is forced to zero when there is no grant.
- On each transfer:
  - wr_ptr_bin increments by 1 with natural wrap at 2^PTR_WIDTH; the MSB is the lap bit.
  - wr_ptr_gray is loaded with bin2gray(next binary pointer).
  - last_grant is loaded with grant_id.
- last_grant holds when there is no transfer. A requester that drops valid without being granted loses nothing.
- Full is recomputed every cycle, including cycles without a write, so a read-pointer advance clears it:
  - full_next = (gray_next == {~rd_ptr_gray_sync[MSB:MSB-1], rd_ptr_gray_sync[MSB-2:0]}).
  - gray_next is the Gray pointer after this cycle's transfer, if any.
- Requesters must hold valid and data stable until granted. The block does not buffer data.
- Reset values (asynchronous): wr_ptr_bin=0, wr_ptr_gray=0, full=0, last_grant=NUM_REQ-1 (so requester 0 wins first), almost_full=0.
- Reset mid-operation: all registers return to their reset values immediately and any in-flight request is dropped. Writes already performed to memory are not undone.

## Timing
- Grant latency is zero cycles: req_ready follows req_valid combinationally within the same cycle.
- The data is written at the same W_clk rising edge on which the transfer occurs.
- wr_ptr_gray, full and almost_full update at that same edge and are visible in the next cycle.
- After the MEM_DEPTH-th unread write, full=1 in the following cycle. No write is accepted while full=1.
- A change on rd_ptr_gray_sync affects full at the next edge. Total release latency back to read-domain pop is therefore synchronizer latency + 1 cycle.
- Simultaneous last-slot write and read-pointer advance: full_next is evaluated with both, so full stays 0.

## Configuration
- FIFO_WR_ALMOST_FULL_EN defined:
  - Converts rd_ptr_gray_sync to binary and computes free = MEM_DEPTH - (wr_bin_next - rd_bin), in PTR_WIDTH-bit arithmetic.
  - Registers almost_full = (free ≤ AF_THRESH).
  - Adds the almost_full port.
- Macro undefined: no almost_full port, no Gray-to-binary conversion logic. All other behaviour is identical.

## Structure
- Package fifo_wr_pkg holds:
  - the bin2gray and gray2bin functions;
  - the clog2-based PTR_WIDTH/ID_WIDTH derivation constants.
- Sub-module rr_arbiter:
  - inputs: req vector, enable (= ~full), last_grant;
  - outputs: one-hot grant and grant_id.
  - It is purely combinational. last_grant stays in the parent.

## Test plan
- After reset, req_valid=4'b1111 held with rd pointer fixed at 0 → grants in order 0,1,2,3,0,1,2,3. full rises the cycle after the 8th write; req_ready=0 thereafter.
- Fill to full, then advance rd_ptr_gray_sync from 0 to Gray(1) → full clears one edge later. Exactly one more write is accepted, to address 0, and full reasserts.
- req_valid=4'b0101 with FIFO not full → alternating grants 0,2,0,2. grant_id and mem_wdata match the granted slice.
- 20 writes interleaved with rd pointer advances → mem_waddr wraps 7→0. wr_ptr_gray follows the Gray sequence, including the MSB flip after address 7.
- Assert W_rst mid-burst at 5 writes → ptr=0, full=0, req_ready=0 during reset. Requester 0 is granted first after release.
- With FIFO_WR_ALMOST_FULL_EN and AF_THRESH=2 → almost_full rises the cycle after the 6th unread write and falls after a read brings free slots to 3.
